// File: rtl/ste_rms_pkg.sv
// Shared definitions for the windowed RMS block.
//   state_e   : controller states (idle, accumulate, square root, done)
//   sum_w()   : width of the running sum of squares
//   params_ok : legal parameter range check, evaluated at elaboration
package ste_rms_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StRoot,
    StDone
  } state_e;

  // Holds N squares of DATA_W-bit samples without overflow.
  function automatic int unsigned sum_w(input int unsigned data_w, input int unsigned win_log2);
    return 2 * data_w + win_log2;
  endfunction

  function automatic bit params_ok(input int unsigned data_w, input int unsigned win_log2);
    return (data_w >= 8) && (data_w <= 24) && (win_log2 >= 1) && (win_log2 <= 10);
  endfunction

endpackage

// File: rtl/ste_rms_win_isqrt.sv
// Sequential non-restoring integer square root.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start_i     : load radicand_i and begin (ignored while abort_i is high)
//   abort_i     : stop a root in progress; done_o is not raised
//   radicand_i  : 2*DATA_W-bit unsigned input
//   done_o      : high in the cycle of the last iteration; root_o is valid then
//   root_o      : floor(sqrt(radicand)), DATA_W bits
// One result bit per cycle, DATA_W cycles after the start edge.
module ste_isqrt #(
  parameter int unsigned DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [2*DATA_W-1:0]   radicand_i,
  output logic                  done_o,
  output logic [DATA_W-1:0]     root_o
);

  // Partial remainder is signed; four guard bits cover the negative swing.
  localparam int unsigned RemW = DATA_W + 4;
  localparam int unsigned CntW = $clog2(DATA_W);
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic                  run_q, run_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [RemW-1:0]       rem_q, rem_d;
  logic [DATA_W-1:0]     root_q, root_d;
  logic [2*DATA_W-1:0]   rad_q, rad_d;

  logic [RemW-1:0]       rem_shift;
  logic [RemW-1:0]       rem_step;
  logic [DATA_W-1:0]     root_step;

  always_comb begin
    rem_shift = {rem_q[RemW-3:0], rad_q[2*DATA_W-1 -: 2]};
    // Non-restoring: subtract 4q+1 after a non-negative remainder, add 4q+3 otherwise.
    if (rem_q[RemW-1]) begin
      rem_step = rem_shift + {2'b00, root_q, 2'b11};
    end else begin
      rem_step = rem_shift - {2'b00, root_q, 2'b01};
    end
    root_step = {root_q[DATA_W-2:0], ~rem_step[RemW-1]};
  end

  always_comb begin
    run_d  = run_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    root_d = root_q;
    rad_d  = rad_q;
    if (abort_i) begin
      run_d = 1'b0;
    end else if (start_i) begin
      run_d  = 1'b1;
      cnt_d  = '0;
      rem_d  = '0;
      root_d = '0;
      rad_d  = radicand_i;
    end else if (run_q) begin
      rem_d  = rem_step;
      root_d = root_step;
      rad_d  = {rad_q[2*DATA_W-3:0], 2'b00};
      cnt_d  = cnt_q + CntOne;
      if (cnt_q == LastCnt) begin
        run_d = 1'b0;
      end
    end
  end

  assign done_o = run_q && (cnt_q == LastCnt) && !abort_i;
  assign root_o = root_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      rad_q  <= '0;
    end else begin
      run_q  <= run_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      root_q <= root_d;
      rad_q  <= rad_d;
    end
  end

endmodule

// File: rtl/ste_rms_win.sv
// RMS over a sliding window of the last N = 2**WIN_LOG2 accepted samples.
//   clk, rst_n     : clock, asynchronous active-low reset
//   din_i          : unsigned sample, taken when din_update_i is high and busy_o is low
//   clr_i          : synchronous clear (wins over din_update_i)
//   dout_o         : floor(sqrt(sum of squares >> WIN_LOG2))
//   dout_update_o  : one-cycle pulse when dout_o is new (DATA_W+2 cycles after acceptance)
//   busy_o         : accumulate/root in progress, incoming samples are dropped
//   valid_o        : N samples accepted since clear
//   ovr_o          : sticky, a sample was dropped
//   peak_o         : only with STE_RMS_WIN_PEAK_EN, largest accepted sample since clear
module ste_rms_win
  import ste_rms_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned WIN_LOG2 = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din_i,
  input  logic              din_update_i,
  input  logic              clr_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              dout_update_o,
  output logic              busy_o,
  output logic              valid_o,
  output logic              ovr_o
`ifdef STE_RMS_WIN_PEAK_EN
  ,
  output logic [DATA_W-1:0] peak_o
`endif
);

  localparam int unsigned SumW  = sum_w(DATA_W, WIN_LOG2);
  localparam int unsigned Depth = 1 << WIN_LOG2;
  localparam logic [WIN_LOG2:0]   FullCnt = {1'b1, {WIN_LOG2{1'b0}}};
  localparam logic [WIN_LOG2:0]   LastCnt = {1'b0, {WIN_LOG2{1'b1}}};
  localparam logic [WIN_LOG2:0]   CntOne  = {{WIN_LOG2{1'b0}}, 1'b1};
  localparam logic [WIN_LOG2-1:0] PtrOne  = {{(WIN_LOG2-1){1'b0}}, 1'b1};

  if (!params_ok(DATA_W, WIN_LOG2)) begin : g_param_err
    $error("ste_rms_win: DATA_W must be 8..24 and WIN_LOG2 1..10");
  end

  state_e              state_q, state_d;
  logic [WIN_LOG2-1:0] ptr_q, ptr_d;
  logic [WIN_LOG2:0]   cnt_q, cnt_d;
  logic [SumW-1:0]     sum_q, sum_d;
  logic [DATA_W-1:0]   samp_q, samp_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                valid_q, valid_d;
  logic                ovr_q, ovr_d;

  // Sample storage has no reset so it can map onto RAM.
  logic [DATA_W-1:0]   win_mem [Depth];
  logic                mem_we;

  logic [DATA_W-1:0]   old_smp;
  logic [2*DATA_W-1:0] new_sq, old_sq;
  logic [SumW-1:0]     sum_acc;
  logic                rt_start, rt_done;
  logic [DATA_W-1:0]   rt_root;

`ifdef STE_RMS_WIN_PEAK_EN
  logic [DATA_W-1:0]   peak_q, peak_d;
`endif

  // Entry being overwritten counts as zero until the window has filled once.
  always_comb begin
    old_smp = (cnt_q == FullCnt) ? win_mem[ptr_q] : '0;
    new_sq  = {{DATA_W{1'b0}}, samp_q} * {{DATA_W{1'b0}}, samp_q};
    old_sq  = {{DATA_W{1'b0}}, old_smp} * {{DATA_W{1'b0}}, old_smp};
    sum_acc = sum_q + {{WIN_LOG2{1'b0}}, new_sq} - {{WIN_LOG2{1'b0}}, old_sq};
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    samp_d   = samp_q;
    dout_d   = dout_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    mem_we   = 1'b0;
    rt_start = 1'b0;
`ifdef STE_RMS_WIN_PEAK_EN
    peak_d   = peak_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (din_update_i) begin
          state_d = StAcc;
          samp_d  = din_i;
          // valid_o rises on the edge that accepts the N-th sample.
          if (cnt_q == LastCnt) begin
            valid_d = 1'b1;
          end
        end
      end
      StAcc: begin
        mem_we   = 1'b1;
        sum_d    = sum_acc;
        ptr_d    = ptr_q + PtrOne;
        rt_start = 1'b1;
        state_d  = StRoot;
        if (cnt_q != FullCnt) begin
          cnt_d = cnt_q + CntOne;
        end
`ifdef STE_RMS_WIN_PEAK_EN
        if (samp_q > peak_q) begin
          peak_d = samp_q;
        end
`endif
        if (din_update_i) begin
          ovr_d = 1'b1;
        end
      end
      StRoot: begin
        if (din_update_i) begin
          ovr_d = 1'b1;
        end
        if (rt_done) begin
          dout_d  = rt_root;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase

    if (clr_i) begin
      state_d  = StIdle;
      ptr_d    = '0;
      cnt_d    = '0;
      sum_d    = '0;
      dout_d   = '0;
      valid_d  = 1'b0;
      ovr_d    = 1'b0;
      mem_we   = 1'b0;
      rt_start = 1'b0;
`ifdef STE_RMS_WIN_PEAK_EN
      peak_d   = '0;
`endif
    end
  end

  ste_isqrt #(
    .DATA_W (DATA_W)
  ) u_isqrt (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (rt_start),
    .abort_i    (clr_i),
    .radicand_i (sum_acc[SumW-1:WIN_LOG2]),
    .done_o     (rt_done),
    .root_o     (rt_root)
  );

  always_ff @(posedge clk) begin
    if (mem_we) begin
      win_mem[ptr_q] <= samp_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      samp_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef STE_RMS_WIN_PEAK_EN
      peak_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      samp_q  <= samp_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
`ifdef STE_RMS_WIN_PEAK_EN
      peak_q  <= peak_d;
`endif
    end
  end

  assign dout_o        = dout_q;
  assign dout_update_o = (state_q == StDone);
  assign busy_o        = (state_q == StAcc) || (state_q == StRoot);
  assign valid_o       = valid_q;
  assign ovr_o         = ovr_q;
`ifdef STE_RMS_WIN_PEAK_EN
  assign peak_o        = peak_q;
`endif

endmodule

// File: tb/tb_ste_rms_win.sv
// Bench for ste_rms_win (DATA_W=16, WIN_LOG2=3): directed table, hand-written corner
// sequences and random stimulus, all checked every cycle against a sample-history model.
module tb_ste_rms_win;

  localparam int DW  = 16;
  localparam int WL  = 3;
  localparam int N   = 1 << WL;
  localparam int LAT = DW + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] din_i;
  logic          din_update_i;
  logic          clr_i;
  logic [DW-1:0] dout_o;
  logic          dout_update_o;
  logic          busy_o;
  logic          valid_o;
  logic          ovr_o;
`ifdef STE_RMS_WIN_PEAK_EN
  logic [DW-1:0] peak_o;
`endif

  ste_rms_win #(
    .DATA_W   (DW),
    .WIN_LOG2 (WL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .din_i         (din_i),
    .din_update_i  (din_update_i),
    .clr_i         (clr_i),
    .dout_o        (dout_o),
    .dout_update_o (dout_update_o),
    .busy_o        (busy_o),
    .valid_o       (valid_o),
    .ovr_o         (ovr_o)
`ifdef STE_RMS_WIN_PEAK_EN
    ,
    .peak_o        (peak_o)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: phase = cycles since the accepting edge (-1 when no calculation pending).
  int      hist[$];
  int      m_cnt;
  int      phase;
  longint  pend;
  longint  m_dout;
  bit      m_valid;
  bit      m_ovr;

  typedef struct {
    logic [DW-1:0] din;
    int            reps;
    longint        exp_dout;
    bit            exp_valid;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, want %0d", nm, $time, act, exp);
    end
  endtask

  function automatic longint isqrt_ref(input longint x);
    longint lo = 0;
    longint hi = 65536;
    while (hi - lo > 1) begin
      longint mid = (lo + hi) / 2;
      if (mid * mid <= x) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction

  // Window = last N accepted samples since clear; missing entries contribute nothing.
  function automatic longint rms_ref();
    longint s = 0;
    foreach (hist[i]) s += longint'(hist[i]) * longint'(hist[i]);
    return isqrt_ref(s / N);
  endfunction

  task automatic model_reset();
    hist.delete();
    m_cnt   = 0;
    phase   = -1;
    pend    = 0;
    m_dout  = 0;
    m_valid = 0;
    m_ovr   = 0;
  endtask

  task automatic model_edge(input bit upd, input int d, input bit c);
    bit busy;
    busy = (phase >= 1) && (phase <= LAT - 1);
    if (c) begin
      model_reset();
    end else if (upd && !busy) begin
      hist.push_back(d);
      if (hist.size() > N) void'(hist.pop_front());
      m_cnt++;
      if (m_cnt >= N) m_valid = 1;
      pend  = rms_ref();
      phase = 1;
    end else begin
      if (upd) m_ovr = 1;
      if (phase >= 1) begin
        phase++;
        if (phase == LAT) m_dout = pend;
        if (phase > LAT) phase = -1;
      end
    end
  endtask

  // One clock: drive, take the edge in the model, then compare on the falling edge.
  task automatic cyc(input bit upd, input logic [DW-1:0] d, input bit c);
    din_update_i = upd;
    din_i        = d;
    clr_i        = c;
    @(posedge clk);
    model_edge(upd, int'(d), c);
    @(negedge clk);
    chk("busy", busy_o, (phase >= 1 && phase <= LAT - 1));
    chk("dout_update", dout_update_o, (phase == LAT));
    chk("dout", dout_o, m_dout);
    chk("valid", valid_o, m_valid);
    chk("ovr", ovr_o, m_ovr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0);
  endtask

  task automatic run_sample(input logic [DW-1:0] d);
    cyc(1'b1, d, 1'b0);
    idle(LAT);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, want finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int pulses;

    tbl[0] = '{din: 16'd1000,  reps: 1, exp_dout: 353,   exp_valid: 1'b0};
    tbl[1] = '{din: 16'd1000,  reps: 7, exp_dout: 1000,  exp_valid: 1'b1};
    tbl[2] = '{din: 16'd0,     reps: 1, exp_dout: 935,   exp_valid: 1'b1};
    tbl[3] = '{din: 16'd0,     reps: 8, exp_dout: 0,     exp_valid: 1'b1};
    tbl[4] = '{din: 16'hFFFF,  reps: 8, exp_dout: 65535, exp_valid: 1'b1};

    rst_n        = 1'b0;
    din_i        = '0;
    din_update_i = 1'b0;
    clr_i        = 1'b0;
    model_reset();
    #3;
    chk("reset_dout", dout_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_valid", valid_o, 0);
    chk("reset_ovr", ovr_o, 0);
    chk("reset_update", dout_update_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Single sample: latency from the accepting edge to the pulse.
    cyc(1'b1, 16'd1000, 1'b0);
    lat = 1;
    while (!dout_update_o && lat < 40) begin
      cyc(1'b0, '0, 1'b0);
      lat++;
    end
    chk("latency", lat, LAT);
    chk("single_dout", dout_o, 353);
    chk("single_valid", valid_o, 0);
    idle(2);
    cyc(1'b0, '0, 1'b1);

    // Directed table: fill, wrap, zero-out, full scale.
    for (int t = 0; t < 5; t++) begin
      for (int r = 0; r < tbl[t].reps; r++) run_sample(tbl[t].din);
      chk($sformatf("tbl%0d_dout", t), dout_o, tbl[t].exp_dout);
      chk($sformatf("tbl%0d_valid", t), valid_o, tbl[t].exp_valid);
    end

    // Sample offered in the fifth ROOT cycle is dropped and flagged.
    cyc(1'b0, '0, 1'b1);
    cyc(1'b1, 16'd500, 1'b0);
    idle(5);
    cyc(1'b1, 16'd777, 1'b0);
    chk("ovr_set", ovr_o, 1);
    idle(LAT);
    chk("ovr_dout", dout_o, 176);
    chk("ovr_sticky", ovr_o, 1);
    cyc(1'b0, '0, 1'b1);
    chk("ovr_clr", ovr_o, 0);

    // Clear during ROOT aborts the result.
    cyc(1'b1, 16'd2000, 1'b0);
    idle(5);
    cyc(1'b0, '0, 1'b1);
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      cyc(1'b0, '0, 1'b0);
      if (dout_update_o) pulses++;
    end
    chk("abort_pulses", pulses, 0);
    chk("abort_dout", dout_o, 0);

    // Clear together with a sample strobe discards the sample.
    cyc(1'b1, 16'd1234, 1'b1);
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      cyc(1'b0, '0, 1'b0);
      if (dout_update_o) pulses++;
    end
    chk("clr_upd_pulses", pulses, 0);
    chk("clr_upd_dout", dout_o, 0);
    run_sample(16'd1000);
    chk("after_clr_dout", dout_o, 353);

    // Random traffic, including strobes while busy and occasional clears.
    for (int i = 0; i < 500; i++) begin
      bit            upd;
      bit            c;
      logic [DW-1:0] d;
      upd = ($urandom_range(0, 99) < 25);
      c   = ($urandom_range(0, 99) < 2);
      d   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : DW'($urandom_range(0, 65535));
      cyc(upd, d, c);
    end
    idle(LAT);

    // Asynchronous reset mid-calculation, away from any clock edge.
    cyc(1'b1, 16'd4321, 1'b0);
    idle(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_dout", dout_o, 0);
    chk("areset_busy", busy_o, 0);
    chk("areset_valid", valid_o, 0);
    chk("areset_ovr", ovr_o, 0);
    chk("areset_update", dout_update_o, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run_sample(16'd1000);
    chk("post_reset_dout", dout_o, 353);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ste_rms_win.md
STE_RMS_WIN -- requirements
Module: ste_rms_win

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning unsigned sample and result width (8..24).
REQ-002 SHALL have parameter WIN_LOG2, default 3, meaning log2 of window depth N (1..10).
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port din_i  input  DATA_W  unsigned sample.
REQ-006 SHALL have port din_update_i  input  1  sample strobe, one cycle per sample.
REQ-007 SHALL have port clr_i  input  1  synchronous clear.
REQ-008 SHALL have port dout_o  output  DATA_W  RMS of the last N samples.
REQ-009 SHALL have port dout_update_o  output  1  one-cycle pulse when dout_o is new.
REQ-010 SHALL have port busy_o  output  1  calculation in progress, samples dropped.
REQ-011 SHALL have port valid_o  output  1  window has held N accepted samples since clear.
REQ-012 SHALL have port ovr_o  output  1  sticky, a sample was dropped.

Function
REQ-013 SHALL store accepted samples in an N-entry circular buffer with a write pointer that wraps from N-1 to 0.
REQ-014 SHALL keep a running sum of squares, width 2*DATA_W+WIN_LOG2, updated as sum + din^2 - old^2; old is the overwritten entry, taken as 0 while the fill count is below N.
REQ-015 SHALL compute mean = sum >> WIN_LOG2 (truncating), always dividing by N, including before the window is full.
REQ-016 SHALL give dout_o = floor(sqrt(mean)), exact with no overflow for every input.
REQ-017 SHALL use FSM states IDLE, ACC, ROOT and DONE.
- IDLE -> ACC on din_update_i.
- ACC: one cycle, update buffer, sum and count.
- ROOT: exactly DATA_W cycles, one result bit per cycle.
- DONE: one cycle, register dout_o, pulse dout_update_o, then go to IDLE.
REQ-018 SHALL give a latency of DATA_W+2 cycles from the accepting edge to the dout_update_o high cycle (18 for DATA_W=16).
REQ-019 SHALL drive busy_o = 1 only in ACC and ROOT, so a sample is accepted in the DONE cycle.
REQ-020 SHALL drop any din_update_i seen while busy_o=1, leaving all state unchanged and setting ovr_o.
REQ-021 SHALL saturate the fill count at N and set valid_o on the edge that accepts the N-th sample.
REQ-022 SHALL, on clr_i, zero the pointer, sum, count, valid_o, ovr_o and dout_o and go to IDLE.
- A ROOT in progress is aborted with no dout_update_o.
- Buffer contents need not be cleared.
REQ-023 SHALL give clr_i priority when it coincides with din_update_i, discarding the sample.

Reset
REQ-024 SHALL, on rst_n low, immediately force the FSM to IDLE and dout_o, dout_update_o, busy_o, valid_o, ovr_o, sum, count and pointer to 0, independent of clk.
REQ-025 SHALL not require a reset on the buffer storage, which may be inferred as RAM.

Configuration
REQ-026 SHALL, with STE_RMS_WIN_PEAK_EN defined, add output peak_o [DATA_W] holding the maximum accepted din_i since reset or clear (reset value 0, updated on the ACC edge).
REQ-027 SHALL, without STE_RMS_WIN_PEAK_EN defined, have neither the peak_o port nor its logic.

Structure
REQ-028 SHALL take the state enum type, the SUM_W width function and the parameter range checks from package ste_rms_pkg.
REQ-029 SHALL implement the root in sub-module ste_isqrt: start/done handshake, abort input, non-restoring, DATA_W cycles, input 2*DATA_W bits, output DATA_W bits.

Verification (DATA_W=16, WIN_LOG2=3)
REQ-030 SHALL cover: one sample 1000 after reset -> dout_o=353, valid_o=0, pulse 18 cycles after acceptance, busy_o high for cycles 1..17.
REQ-031 SHALL cover: eight samples of 1000 -> final dout_o=1000, valid_o=1.
REQ-032 SHALL cover wrap: then one sample 0 -> dout_o=935; after eight samples of 0 -> dout_o=0, valid_o=1.
REQ-033 SHALL cover: eight samples of 65535 -> dout_o=65535, no sum overflow.
REQ-034 SHALL cover: din_update_i at cycle 5 of ROOT -> sample ignored and ovr_o=1; then clr_i -> ovr_o=0.
REQ-035 SHALL cover: clr_i during ROOT, and clr_i together with din_update_i -> no dout_update_o, dout_o=0, next sample gives the single-sample result.
